// File: rtl/y86_regfile_wb.sv
// Y86-64 register file: decode-side source select and reads, writeback-side
// destination select and commit, plus a RUN/HALT state machine.
module y86_regfile_wb #(
    parameter int unsigned DATA_WID = 64,
    parameter int unsigned NREG     = 15,
    parameter logic [3:0]  RSP_ID   = 4'd4
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                wb_en,
    input  logic [3:0]          icode,
    input  logic [3:0]          ifun,
    input  logic [3:0]          rA,
    input  logic [3:0]          rB,
    input  logic                Cnd,
    input  logic [DATA_WID-1:0] valE,
    input  logic [DATA_WID-1:0] valM,
    output logic [DATA_WID-1:0] valA,
    output logic [DATA_WID-1:0] valB,
    output logic [3:0]          dstE,
    output logic [3:0]          dstM,
    output logic                halted,
    input  logic [3:0]          dbg_sel,
    output logic [DATA_WID-1:0] dbg_val
);

    localparam logic [3:0] RNONE = 4'hF;

    typedef enum logic {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [DATA_WID-1:0] regs [NREG];
    logic [3:0]          src_a;
    logic [3:0]          src_b;
    logic [3:0]          dst_e;
    logic [3:0]          dst_m;
    logic                halt_ins;
    logic                commit;

    // The cmov condition reaches us through Cnd, so ifun carries no information here.
    logic unused_ifun;
    assign unused_ifun = ^ifun;

    // Source and destination decode from icode/rA/rB
    always_comb begin
        src_a = RNONE;
        src_b = RNONE;
        dst_e = RNONE;
        dst_m = RNONE;
        case (icode)
            4'h2: begin
                src_a = rA;
                dst_e = Cnd ? rB : RNONE;
            end
            4'h3: dst_e = rB;
            4'h4: begin
                src_a = rA;
                src_b = rB;
            end
            4'h5: begin
                src_b = rB;
                dst_m = rA;
            end
            4'h6: begin
                src_a = rA;
                src_b = rB;
                dst_e = rB;
            end
            4'h8: begin
                src_b = RSP_ID;
                dst_e = RSP_ID;
            end
            4'h9: begin
                src_a = RSP_ID;
                src_b = RSP_ID;
                dst_e = RSP_ID;
            end
            4'hA: begin
                src_a = rA;
                src_b = RSP_ID;
                dst_e = RSP_ID;
            end
            4'hB: begin
                src_a = RSP_ID;
                src_b = RSP_ID;
                dst_e = RSP_ID;
                dst_m = rA;
            end
            default: ;
        endcase
    end

    assign dstE = dst_e;
    assign dstM = dst_m;

    function automatic logic [DATA_WID-1:0] rd(input logic [3:0] id);
        if (id == RNONE || 32'(id) >= NREG) begin
            return '0;
        end
        return regs[id];
    endfunction

    assign valA    = rd(src_a);
    assign valB    = rd(src_b);
    assign dbg_val = rd(dbg_sel);

    assign halt_ins = (icode == 4'h0) || (icode > 4'hB);
    assign commit   = wb_en && (state_q == S_RUN);

    // Next-state logic: HALT absorbs until reset
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN:   if (wb_en && halt_ins) state_d = S_HALT;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    assign halted = (state_q == S_HALT);

    // M port is written last so it wins when both destinations coincide (popq %rsp)
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs[i] <= '0;
            end
        end else if (commit) begin
            if (dst_e != RNONE && 32'(dst_e) < NREG) begin
                regs[dst_e] <= valE;
            end
            if (dst_m != RNONE && 32'(dst_m) < NREG) begin
                regs[dst_m] <= valM;
            end
        end
    end

endmodule

// File: tb/tb_y86_regfile_wb.sv
// Scoreboard bench for y86_regfile_wb: stimulus queues expectations, a
// negedge monitor pops and compares them against the DUT outputs.
module tb_y86_regfile_wb;

    localparam int unsigned DW = 64;

    localparam int K_VALA = 0;
    localparam int K_VALB = 1;
    localparam int K_DSTE = 2;
    localparam int K_DSTM = 3;
    localparam int K_HALT = 4;
    localparam int K_DBG  = 5;

    typedef struct {
        int          kind;
        logic [63:0] exp;
        string       name;
    } exp_t;

    logic          CLK;
    logic          RST;
    logic          wb_en;
    logic [3:0]    icode;
    logic [3:0]    ifun;
    logic [3:0]    rA;
    logic [3:0]    rB;
    logic          Cnd;
    logic [DW-1:0] valE;
    logic [DW-1:0] valM;
    logic [DW-1:0] valA;
    logic [DW-1:0] valB;
    logic [3:0]    dstE;
    logic [3:0]    dstM;
    logic          halted;
    logic [3:0]    dbg_sel;
    logic [DW-1:0] dbg_val;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    y86_regfile_wb dut (
        .CLK     (CLK),
        .RST     (RST),
        .wb_en   (wb_en),
        .icode   (icode),
        .ifun    (ifun),
        .rA      (rA),
        .rB      (rB),
        .Cnd     (Cnd),
        .valE    (valE),
        .valM    (valM),
        .valA    (valA),
        .valB    (valB),
        .dstE    (dstE),
        .dstM    (dstM),
        .halted  (halted),
        .dbg_sel (dbg_sel),
        .dbg_val (dbg_val)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Monitor: outputs are sampled mid-cycle, away from the active edge
    always @(negedge CLK) begin
        while (sb.size() > 0) begin
            exp_t        e;
            logic [63:0] act;
            e = sb.pop_front();
            case (e.kind)
                K_VALA:  act = valA;
                K_VALB:  act = valB;
                K_DSTE:  act = 64'(dstE);
                K_DSTM:  act = 64'(dstM);
                K_HALT:  act = 64'(halted);
                default: act = dbg_val;
            endcase
            n_tests++;
            if (act !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
            end
        end
    end

    task automatic expect_val(input int kind, input logic [63:0] exp, input string name);
        exp_t e;
        e.kind = kind;
        e.exp  = exp;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic en, input logic [3:0] ic, input logic [3:0] a,
                         input logic [3:0] b, input logic c,
                         input logic [63:0] e, input logic [63:0] m);
        wb_en = en;
        icode = ic;
        rA    = a;
        rB    = b;
        Cnd   = c;
        valE  = e;
        valM  = m;
    endtask

    // Idle cycle that inspects one register through the debug port
    task automatic peek(input logic [3:0] sel, input logic [63:0] exp, input string name);
        drive(1'b0, 4'h1, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0);
        dbg_sel = sel;
        expect_val(K_DBG, exp, name);
        step();
    endtask

    initial begin
        RST     = 1'b1;
        ifun    = 4'h0;
        dbg_sel = 4'h0;
        drive(1'b0, 4'h1, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0);
        step();
        step();
        RST = 1'b0;

        // Reset state, then irmovq $0x1234, %rdx
        dbg_sel = 4'h2;
        drive(1'b1, 4'h3, 4'hF, 4'h2, 1'b0, 64'h1234, 64'h0);
        expect_val(K_HALT, 64'h0, "halted_after_reset");
        expect_val(K_DBG, 64'h0, "reg2_before_write");
        expect_val(K_DSTE, 64'h2, "irmovq_dstE");
        expect_val(K_DSTM, 64'hF, "irmovq_dstM");
        step();
        peek(4'h2, 64'h1234, "reg2_after_irmovq");
        peek(4'h0, 64'h0, "reg0_after_reset");

        // cmovXX %rdx, %rbx with condition false then true
        drive(1'b1, 4'h2, 4'h2, 4'h3, 1'b0, 64'h55, 64'h0);
        expect_val(K_DSTE, 64'hF, "cmov_cnd0_dstE");
        expect_val(K_VALA, 64'h1234, "cmov_valA");
        step();
        peek(4'h3, 64'h0, "reg3_after_cmov_cnd0");
        drive(1'b1, 4'h2, 4'h2, 4'h3, 1'b1, 64'h55, 64'h0);
        expect_val(K_DSTE, 64'h3, "cmov_cnd1_dstE");
        step();
        peek(4'h3, 64'h55, "reg3_after_cmov_cnd1");

        // Seed reg1=7, reg4=0x100
        drive(1'b1, 4'h3, 4'hF, 4'h1, 1'b0, 64'h7, 64'h0);
        step();
        drive(1'b1, 4'h3, 4'hF, 4'h4, 1'b0, 64'h100, 64'h0);
        step();

        // pushq %rcx
        drive(1'b1, 4'hA, 4'h1, 4'hF, 1'b0, 64'hF8, 64'h0);
        expect_val(K_VALA, 64'h7, "pushq_valA");
        expect_val(K_VALB, 64'h100, "pushq_valB");
        expect_val(K_DSTE, 64'h4, "pushq_dstE");
        step();
        peek(4'h4, 64'hF8, "reg4_after_pushq");

        // popq %rsp: M port beats E port on the same register
        drive(1'b1, 4'hB, 4'h4, 4'hF, 1'b0, 64'h108, 64'hABCD);
        expect_val(K_DSTE, 64'h4, "popq_dstE");
        expect_val(K_DSTM, 64'h4, "popq_dstM");
        expect_val(K_VALA, 64'hF8, "popq_valA");
        step();
        peek(4'h4, 64'hABCD, "reg4_after_popq_rsp");

        // mrmovq 0(%rdx), %rdi
        drive(1'b1, 4'h5, 4'h7, 4'h2, 1'b0, 64'h0, 64'h77);
        expect_val(K_VALA, 64'h0, "mrmovq_valA_rnone");
        expect_val(K_VALB, 64'h1234, "mrmovq_valB");
        expect_val(K_DSTM, 64'h7, "mrmovq_dstM");
        step();
        peek(4'h7, 64'h77, "reg7_after_mrmovq");

        // OPq %rdx, %rbx
        drive(1'b1, 4'h6, 4'h2, 4'h3, 1'b0, 64'h99, 64'h0);
        expect_val(K_VALB, 64'h55, "opq_valB");
        step();
        peek(4'h3, 64'h99, "reg3_after_opq");
        peek(4'hF, 64'h0, "dbg_rnone_reads_zero");

        // wb_en=0: decode follows inputs but nothing commits
        drive(1'b0, 4'h3, 4'hF, 4'h8, 1'b0, 64'hDEAD, 64'h0);
        expect_val(K_DSTE, 64'h8, "idle_dstE_decoded");
        step();
        peek(4'h8, 64'h0, "reg8_no_write_when_idle");

        // halt freezes state
        drive(1'b1, 4'h0, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0);
        expect_val(K_HALT, 64'h0, "halted_before_halt_edge");
        step();
        drive(1'b1, 4'h3, 4'hF, 4'h5, 1'b0, 64'h9, 64'h0);
        expect_val(K_HALT, 64'h1, "halted_after_halt");
        step();
        peek(4'h5, 64'h0, "reg5_frozen_after_halt");

        // Reset from HALT returns to RUN and writes resume
        RST = 1'b1;
        drive(1'b0, 4'h1, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0);
        step();
        RST = 1'b0;
        drive(1'b1, 4'h3, 4'hF, 4'h5, 1'b0, 64'h9, 64'h0);
        expect_val(K_HALT, 64'h0, "halted_cleared_by_reset");
        step();
        peek(4'h5, 64'h9, "reg5_after_reset_from_halt");

        // Invalid icode 0xC halts as well
        drive(1'b1, 4'hC, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0);
        step();
        drive(1'b1, 4'h3, 4'hF, 4'h5, 1'b0, 64'h1, 64'h0);
        expect_val(K_HALT, 64'h1, "halted_after_invalid");
        step();
        peek(4'h5, 64'h9, "reg5_frozen_after_invalid");

        // Reset on the same edge as a write discards the write
        RST = 1'b1;
        drive(1'b1, 4'h3, 4'hF, 4'h6, 1'b0, 64'h1, 64'h0);
        step();
        RST = 1'b0;
        expect_val(K_HALT, 64'h0, "halted_after_reset_with_write");
        peek(4'h6, 64'h0, "reg6_write_discarded_by_reset");
        peek(4'h5, 64'h0, "reg5_cleared_by_reset");
        drive(1'b1, 4'h3, 4'hF, 4'h6, 1'b0, 64'h1, 64'h0);
        step();
        peek(4'h6, 64'h1, "reg6_after_reset_commit");

        step();
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/y86_regfile_wb.md
Name: y86_regfile_wb

Overview:
- Y86-64 register file serving both ends of the execute stage.
- Decode side: derives srcA/srcB from icode/rA/rB and drives valA/valB to the ALU.
- Writeback side: consumes the ALU's valE/Cnd and memory's valM, derives dstE/dstM and commits on the clock edge.
- Contains a RUN/HALT state machine that freezes architectural state after halt or an invalid instruction.

Parameters:
- DATA_WID, 64, register and data width.
- NREG, 15, architectural registers (IDs 0..14); ID 4'hF = RNONE.
- RSP_ID, 4, stack pointer register ID.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  synchronous, active-high reset.
- wb_en  input  1  instruction valid this cycle; writes and halt detection only when 1.
- icode  input  4  instruction code.
- ifun  input  4  function code (write decode ignores it; cmov condition arrives via Cnd).
- rA  input  4  rA field.
- rB  input  4  rB field.
- Cnd  input  1  condition result from ALU; gates cmovXX writeback.
- valE  input  DATA_WID  ALU result.
- valM  input  DATA_WID  memory read data.
- valA  output  DATA_WID  read data for srcA.
- valB  output  DATA_WID  read data for srcB.
- dstE  output  4  decoded E destination (after Cnd gating).
- dstM  output  4  decoded M destination.
- halted  output  1  1 in HALT state.
- dbg_sel  input  4  debug read select.
- dbg_val  output  DATA_WID  debug read data.

Behaviour:
- Source decode (combinational):
  - srcA = rA for icode 2,4,6,A; RSP_ID for 9,B; else F.
  - srcB = rB for 4,5,6; RSP_ID for 8,9,A,B; else F.
- Destination decode (combinational):
  - dstE = rB for icode 3,6; for icode 2, rB when Cnd=1 else F; RSP_ID for 8,9,A,B; else F.
  - dstM = rA for 5,B; else F.
- Reads are combinational from current register contents; no write-to-read bypass. A value written at edge N is visible on valA/valB after edge N.
- Read of ID F returns 0; dbg_val follows the same rule.
- Write commit at rising CLK when wb_en=1, state=RUN and RST=0:
  - reg[dstE] <= valE if dstE != F.
  - reg[dstM] <= valM if dstM != F.
  - If dstE == dstM != F (popq %rsp), valM wins.
- State machine, 2 states:
  - RUN -> HALT on a clock edge with wb_en=1 and (icode==0 or icode>4'hB).
  - The halt/invalid instruction itself writes nothing: it has no destinations.
  - HALT is absorbing until RST; in HALT all writes are suppressed regardless of wb_en.
  - halted = (state==HALT), registered.
- Reset (synchronous):
  - All NREG registers <= 0; state <= RUN; halted = 0 the cycle after the reset edge.
  - Consequently valA = valB = dbg_val = 0 after reset.
  - RST has priority over any simultaneous write or halt transition.
  - RST asserted mid-stream discards that cycle's write.
- wb_en=0: no write, no state change; decode outputs still reflect inputs.
- All arithmetic is done upstream; this block performs no width conversion, and values are stored verbatim at DATA_WID bits.

Test Plan:
- Reset then irmovq (icode 3, rB=2, valE=64'h1234, wb_en=1) -> dbg_sel=2 gives 64'h1234 after the edge; valA/valB = 0 before it.
- cmovXX rA=2, rB=3, valE=64'h55:
  - Cnd=0 -> dstE=F, reg3 unchanged at 0.
  - Cnd=1 -> dstE=3, reg3=64'h55.
- popq %rsp (icode B, rA=4, valE=64'h108, valM=64'hABCD) -> dstE=dstM=4; reg4=64'hABCD (M priority).
- pushq rA=1 with reg1=7, reg4=64'h100 -> srcA=1, srcB=4; valA=7 and valB=64'h100 combinationally; after edge with valE=64'hF8, reg4=64'hF8.
- halt (icode 0, wb_en=1) -> halted=1 next cycle. A subsequent irmovq to reg5 with valE=9 leaves reg5=0. Same result with icode=4'hC.
- RST asserted on the same edge as irmovq to reg6 (valE=1) -> reg6=0, halted=0. Reset from HALT state returns to RUN, and the next write commits.
